// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register / ID stage and the write-back register file.
// The master drives the write-back bundle and the read indices; the slave (the register file)
// returns read data, the selected write-back value and the retired-write count.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  // MEM/WB write-back bundle
  logic              wwreg;
  logic              wm2reg;
  logic [ADDR_W-1:0] wdestReg;
  logic [DATA_W-1:0] wr;
  logic [DATA_W-1:0] wdo;

  // ID-stage operand reads and debug read
  logic [ADDR_W-1:0] rna;
  logic [ADDR_W-1:0] rnb;
  logic [ADDR_W-1:0] dbg_rn;

  // Results from the register file
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic [DATA_W-1:0] wbData;
  logic [DATA_W-1:0] dbg_q;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output wwreg, wm2reg, wdestReg, wr, wdo, rna, rnb, dbg_rn,
    input  qa, qb, wbData, dbg_q, retire_count
  );

  modport slave (
    input  wwreg, wm2reg, wdestReg, wr, wdo, rna, rnb, dbg_rn,
    output qa, qb, wbData, dbg_q, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it to a 2R1W
// register file with r0 hardwired to zero, serves ID-stage reads with same-cycle
// write-through bypass, and counts retired (committed) writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  retire_cnt;
  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [DATA_W-1:0] qa_d;
  logic [DATA_W-1:0] qb_d;
  logic [DATA_W-1:0] dbg_d;

  // Load data or ALU result; this is exactly what is committed and bypassed.
  assign wb_data = bus.wm2reg ? bus.wdo : bus.wr;

  // A write retires only outside reset and never to r0; this single term gates storage,
  // counting and bypass so all three always agree.
  assign commit = !reset && bus.wwreg && (bus.wdestReg != '0);

  // Storage update: reset clears every entry, otherwise commit the selected value.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the whole array is cleared on reset because software may read any register
      // before writing it; this forces flops rather than a RAM macro, which is intended here.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      // NOTE: state is updated with non-blocking assignments so every always_ff sees the
      // pre-edge values and simulation matches the synthesized flops.
      regs[bus.wdestReg] <= wb_data;
    end
  end

  // Retired-write counter; wraps naturally at 2**CNT_W.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Read port A: r0 reads zero, a matching commit is forwarded, otherwise storage.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    qa_d = regs[bus.rna];
    if (bus.rna == '0) begin
      qa_d = '0;
    end else if (commit && (bus.wdestReg == bus.rna)) begin
      qa_d = wb_data;
    end
  end

  // Read port B: same rules as port A, independent index.
  always_comb begin
    qb_d = regs[bus.rnb];
    if (bus.rnb == '0) begin
      qb_d = '0;
    end else if (commit && (bus.wdestReg == bus.rnb)) begin
      qb_d = wb_data;
    end
  end

  // Debug port: raw storage with no bypass, so it lags a commit by one cycle.
  always_comb begin
    dbg_d = regs[bus.dbg_rn];
    if (bus.dbg_rn == '0) begin
      dbg_d = '0;
    end
  end

  assign bus.wbData       = wb_data;
  assign bus.qa           = qa_d;
  assign bus.qb           = qb_d;
  assign bus.dbg_q        = dbg_d;
  assign bus.retire_count = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven per-cycle vectors plus hand-written
// sequences for the reset sweep and the retired-write counter wrap (narrow-counter instance).
module tb_wb_regfile;

  logic clock;
  logic reset;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_s ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus_s.wwreg    = bus.wwreg;
  assign bus_s.wm2reg   = bus.wm2reg;
  assign bus_s.wdestReg = bus.wdestReg;
  assign bus_s.wr       = bus.wr;
  assign bus_s.wdo      = bus.wdo;
  assign bus_s.rna      = bus.rna;
  assign bus_s.rnb      = bus.rnb;
  assign bus_s.dbg_rn   = bus.dbg_rn;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus plus the outputs expected before that cycle's rising edge.
  typedef struct {
    logic        rst;
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  dest;
    logic [31:0] wr;
    logic [31:0] wdo;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [4:0]  dbg;
    logic [31:0] exp_qa;
    logic [31:0] exp_qb;
    logic [31:0] exp_wb;
    logic [31:0] exp_dbg;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic drive(input logic rst, input logic ww, input logic m2, input logic [4:0] dest,
                       input logic [31:0] wr, input logic [31:0] wdo,
                       input logic [4:0] rna, input logic [4:0] rnb, input logic [4:0] dbg);
    reset        = rst;
    bus.wwreg    = ww;
    bus.wm2reg   = m2;
    bus.wdestReg = dest;
    bus.wr       = wr;
    bus.wdo      = wdo;
    bus.rna      = rna;
    bus.rnb      = rnb;
    bus.dbg_rn   = dbg;
  endtask

  initial begin
    //              rst ww m2 dest wr            wdo           rna rnb dbg  qa            qb            wbData        dbg_q         cnt
    vecs[0]  = '{1'b0,1'b1,1'b0, 5, 32'hDEADBEEF, 32'h0,        5,  0,  5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,        5,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1};
    vecs[2]  = '{1'b0,1'b1,1'b1, 7, 32'h1,        32'h12345678, 7,  7,  7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        1};
    vecs[3]  = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,        7,  5,  7,  32'h12345678, 32'hDEADBEEF, 32'h0,        32'h12345678, 2};
    vecs[4]  = '{1'b0,1'b1,1'b0, 0, 32'hFFFFFFFF, 32'h0,        0,  0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        2};
    vecs[5]  = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,        0,  7,  0,  32'h0,        32'h12345678, 32'h0,        32'h0,        2};
    vecs[6]  = '{1'b0,1'b0,1'b0, 5, 32'h11111111, 32'h22222222, 5,  0,  5,  32'hDEADBEEF, 32'h0,        32'h11111111, 32'hDEADBEEF, 2};
    vecs[7]  = '{1'b0,1'b1,1'b0, 3, 32'h1,        32'h0,        3,  5,  3,  32'h1,        32'hDEADBEEF, 32'h1,        32'h0,        2};
    vecs[8]  = '{1'b0,1'b1,1'b0, 3, 32'h2,        32'h0,        3,  3,  3,  32'h2,        32'h2,        32'h2,        32'h1,        3};
    vecs[9]  = '{1'b0,1'b1,1'b0, 3, 32'h3,        32'h0,        3,  3,  3,  32'h3,        32'h3,        32'h3,        32'h2,        4};
    vecs[10] = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,        3,  0,  3,  32'h3,        32'h0,        32'h0,        32'h3,        5};
    vecs[11] = '{1'b1,1'b1,1'b0, 9, 32'hA5A5A5A5, 32'h0,        9,  9,  9,  32'h0,        32'h0,        32'hA5A5A5A5, 32'h0,        5};
    vecs[12] = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,        9,  3,  5,  32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[13] = '{1'b0,1'b1,1'b0,31, 32'hCAFEF00D, 32'h0,       31, 30, 31,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        0};
    vecs[14] = '{1'b0,1'b0,1'b0, 0, 32'h0,        32'h0,       31,  0, 31,  32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D, 1};

    // Reset for one clock edge with idle inputs.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Every index reads zero on all ports after reset, counters cleared.
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(i), 5'(i));
      #1;
      check($sformatf("reset_qa[%0d]", i), bus.qa, 32'h0);
      check($sformatf("reset_qb[%0d]", i), bus.qb, 32'h0);
      check($sformatf("reset_dbg[%0d]", i), bus.dbg_q, 32'h0);
    end
    check("reset_cnt", bus.retire_count, 32'h0);
    check("reset_cnt_s", {28'h0, bus_s.retire_count}, 32'h0);

    // Table-driven cycles: bypass, load select, r0, gating, back-to-back, reset priority.
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clock);
      drive(vecs[v].rst, vecs[v].wwreg, vecs[v].wm2reg, vecs[v].dest, vecs[v].wr, vecs[v].wdo,
            vecs[v].rna, vecs[v].rnb, vecs[v].dbg);
      #1;
      check($sformatf("v%0d_qa", v), bus.qa, vecs[v].exp_qa);
      check($sformatf("v%0d_qb", v), bus.qb, vecs[v].exp_qb);
      check($sformatf("v%0d_wbData", v), bus.wbData, vecs[v].exp_wb);
      check($sformatf("v%0d_dbg_q", v), bus.dbg_q, vecs[v].exp_dbg);
      check($sformatf("v%0d_cnt", v), bus.retire_count, vecs[v].exp_cnt);
      check($sformatf("v%0d_cnt_s", v), {28'h0, bus_s.retire_count}, vecs[v].exp_cnt & 32'hF);
    end

    // Counter wrap: clear, then 16 committed writes; the 4-bit counter wraps 15 -> 0.
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b0, 5'd1, 32'(i + 100), 32'h0, 5'd1, 5'd0, 5'd1);
      #1;
      check($sformatf("wrap_cnt_s[%0d]", i), {28'h0, bus_s.retire_count}, 32'(i));
      check($sformatf("wrap_qa[%0d]", i), bus.qa, 32'(i + 100));
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd1);
    #1;
    check("wrap_cnt_s_final", {28'h0, bus_s.retire_count}, 32'h0);
    check("wrap_cnt_final", bus.retire_count, 32'd16);
    check("wrap_dbg_final", bus.dbg_q, 32'd115);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
